// File: rtl/sync_fifo_param_pkg.sv
// ---------------------------------------------------------------------------
// fifo_pkg
// Shared definitions for the parametrised synchronous FIFO:
//   DEF_DATA_WIDTH / DEF_DEPTH : default geometry used by the top and interface
//   addr_w()                   : index width for a given depth
//   fifo_status_t              : the registered level flags, kept as one word
//   STATUS_RESET               : flag values of an empty FIFO (reset / flush)
// ---------------------------------------------------------------------------
package fifo_pkg;

    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_DEPTH      = 32;

    // Storage index width. The pointers carry one extra wrap bit on top.
    function automatic int addr_w(input int depth);
        return $clog2(depth);
    endfunction

    typedef struct packed {
        logic full;
        logic empty;
        logic almost_full;
        logic almost_empty;
    } fifo_status_t;

    // An empty FIFO is always almost_empty (AE_THRESH >= 0) and never
    // almost_full (AF_THRESH >= 1), so this holds for every legal threshold.
    localparam fifo_status_t STATUS_RESET = '{
        full:         1'b0,
        empty:        1'b1,
        almost_full:  1'b0,
        almost_empty: 1'b1
    };

endpackage

// File: rtl/sync_fifo_param_if.sv
// ---------------------------------------------------------------------------
// sync_fifo_param_if
// Producer/consumer bundle of the synchronous FIFO. Clock and reset are kept
// outside the bundle as plain ports.
//   master : the side driving flush/wr_en/data_in/rd_en (producer + consumer)
//   slave  : the FIFO itself
// Signals:
//   flush         sync clear of contents, pointers and flags
//   wr_en/data_in write request and data
//   rd_en         read request (FWFT: pop)
//   data_out      read data, rd_valid marks it as valid
//   full/empty/almost_full/almost_empty/count   occupancy status
//   overflow/underflow                          sticky error flags
// ---------------------------------------------------------------------------
interface sync_fifo_param_if
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int DEPTH      = DEF_DEPTH
);

    localparam int ADDR_W = addr_w(DEPTH);

    logic                  flush;
    logic                  wr_en;
    logic [DATA_WIDTH-1:0] data_in;
    logic                  rd_en;
    logic [DATA_WIDTH-1:0] data_out;
    logic                  rd_valid;
    logic                  full;
    logic                  empty;
    logic                  almost_full;
    logic                  almost_empty;
    logic [ADDR_W:0]       count;
    logic                  overflow;
    logic                  underflow;

    modport master (
        output flush, wr_en, data_in, rd_en,
        input  data_out, rd_valid, full, empty, almost_full, almost_empty,
               count, overflow, underflow
    );

    modport slave (
        input  flush, wr_en, data_in, rd_en,
        output data_out, rd_valid, full, empty, almost_full, almost_empty,
               count, overflow, underflow
    );

endinterface

// File: rtl/sync_fifo_param_mem.sv
// ---------------------------------------------------------------------------
// fifo_mem
// Simple dual-port storage array for the FIFO: one synchronous write port,
// one asynchronous read port. DATA_WIDTH x DEPTH.
//   clk      write clock
//   we_i     write enable
//   waddr_i  write index
//   wdata_i  write data
//   raddr_i  read index
//   rdata_o  read data (combinational from raddr_i)
// ---------------------------------------------------------------------------
module fifo_mem #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 32,
    parameter int ADDR_W     = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  we_i,
    input  logic [ADDR_W-1:0]     waddr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic [ADDR_W-1:0]     raddr_i,
    output logic [DATA_WIDTH-1:0] rdata_o
);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    // NOTE: the array has no reset on purpose. Validity is tracked entirely by
    // the pointers in the top level, and a reset here would prevent mapping
    // onto RAM macros / distributed RAM.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/sync_fifo_param.sv
// ---------------------------------------------------------------------------
// sync_fifo_param
// Parametrised single-clock FIFO with occupancy count, almost-full/empty
// thresholds, sticky overflow/underflow, synchronous flush and an optional
// first-word-fall-through read side.
//   clk   rising-edge clock
//   rst   asynchronous, active-low reset
//   bus   sync_fifo_param_if.slave (handshake, data and status)
// Parameters:
//   DATA_WIDTH, DEPTH (power of 2, >= 4)
//   AF_THRESH  almost_full  when count >= AF_THRESH (1..DEPTH)
//   AE_THRESH  almost_empty when count <= AE_THRESH (0..DEPTH-1)
//   FWFT       0: data_out loaded one cycle after an accepted read
//              1: data_out always shows the head word while non-empty
// Every output is driven straight from a flop.
// ---------------------------------------------------------------------------
module sync_fifo_param
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int DEPTH      = DEF_DEPTH,
    parameter int AF_THRESH  = 28,
    parameter int AE_THRESH  = 4,
    parameter int FWFT       = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    sync_fifo_param_if.slave      bus
);

    localparam int ADDR_W = addr_w(DEPTH);

    // Pointers and count share the ADDR_W+1 width: the MSB of a pointer is
    // its wrap bit, and count spans 0..DEPTH inclusive.
    typedef logic [ADDR_W:0] ptr_t;

    localparam ptr_t PTR_ONE  = ptr_t'(1);
    localparam ptr_t AF_LEVEL = ptr_t'(AF_THRESH);
    localparam ptr_t AE_LEVEL = ptr_t'(AE_THRESH);

    ptr_t                  wr_ptr_q, wr_ptr_d;
    ptr_t                  rd_ptr_q, rd_ptr_d;
    ptr_t                  count_q, count_d;
    fifo_status_t          status_q, status_d;
    logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
    logic                  rd_valid_q, rd_valid_d;
    logic                  overflow_q, overflow_d;
    logic                  underflow_q, underflow_d;

    logic                  wr_accept;
    logic                  rd_accept;
    logic [ADDR_W-1:0]     rd_addr;
    logic [DATA_WIDTH-1:0] mem_rdata;
    logic [DATA_WIDTH-1:0] head_word;

    // Gating uses this cycle's registered flags only: a write while full is
    // dropped even if a read frees a slot in the same cycle, and vice versa.
    assign wr_accept = bus.wr_en && !status_q.full;
    assign rd_accept = bus.rd_en && !status_q.empty;

    // Registered read reads the current head; FWFT preloads the head that
    // will be current after this cycle's pop.
    assign rd_addr = (FWFT != 0) ? rd_ptr_d[ADDR_W-1:0] : rd_ptr_q[ADDR_W-1:0];

    fifo_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .ADDR_W     (ADDR_W)
    ) u_mem (
        .clk     (clk),
        .we_i    (wr_accept && !bus.flush),
        .waddr_i (wr_ptr_q[ADDR_W-1:0]),
        .wdata_i (bus.data_in),
        .raddr_i (rd_addr),
        .rdata_o (mem_rdata)
    );

    // The slot being written this cycle is not in the array yet. In FWFT mode
    // the next head can be exactly that slot (write into an empty FIFO, or a
    // pop leaving only the incoming word), so forward the write data.
    // In registered mode an accepted read never targets the slot being
    // written: that would need the FIFO to be full, which blocks the write.
    assign head_word = ((FWFT != 0) && wr_accept && (rd_addr == wr_ptr_q[ADDR_W-1:0]))
                     ? bus.data_in : mem_rdata;

    // NOTE: every variable assigned here gets a default at the top of the
    // block, so no path leaves one unassigned and no latch is inferred.
    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        overflow_d  = overflow_q  || (bus.wr_en && status_q.full);
        underflow_d = underflow_q || (bus.rd_en && status_q.empty);

        if (wr_accept) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (rd_accept) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end

        unique case ({wr_accept, rd_accept})
            2'b10:   count_d = count_q + PTR_ONE;
            2'b01:   count_d = count_q - PTR_ONE;
            default: count_d = count_q;
        endcase

        status_d.empty        = (wr_ptr_d == rd_ptr_d);
        status_d.full         = (wr_ptr_d[ADDR_W-1:0] == rd_ptr_d[ADDR_W-1:0]) &&
                                (wr_ptr_d[ADDR_W] != rd_ptr_d[ADDR_W]);
        status_d.almost_full  = (count_d >= AF_LEVEL);
        status_d.almost_empty = (count_d <= AE_LEVEL);

        if (FWFT != 0) begin
            rd_valid_d = !status_d.empty;
            data_out_d = status_d.empty ? data_out_q : head_word;
        end else begin
            rd_valid_d = rd_accept;
            data_out_d = rd_accept ? head_word : data_out_q;
        end

        // Flush lands in the reset state and overrides any same-cycle access.
        if (bus.flush) begin
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            count_d     = '0;
            status_d    = STATUS_RESET;
            data_out_d  = '0;
            rd_valid_d  = 1'b0;
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values, independent of statement or process order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            status_q    <= STATUS_RESET;
            data_out_q  <= '0;
            rd_valid_q  <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            status_q    <= status_d;
            data_out_q  <= data_out_d;
            rd_valid_q  <= rd_valid_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    assign bus.data_out     = data_out_q;
    assign bus.rd_valid     = rd_valid_q;
    assign bus.full         = status_q.full;
    assign bus.empty        = status_q.empty;
    assign bus.almost_full  = status_q.almost_full;
    assign bus.almost_empty = status_q.almost_empty;
    assign bus.count        = count_q;
    assign bus.overflow     = overflow_q;
    assign bus.underflow    = underflow_q;

endmodule

// File: tb/tb_sync_fifo_param.sv
// ---------------------------------------------------------------------------
// tb_sync_fifo_param
// Directed bench for sync_fifo_param at 8x16, AF_THRESH=14, AE_THRESH=2.
// dut_a runs in registered-read mode, dut_b in first-word-fall-through mode.
// Inputs change 1 time unit after a rising edge; outputs are sampled there.
// ---------------------------------------------------------------------------
module tb_sync_fifo_param;

    localparam int DW    = 8;
    localparam int DEPTH = 16;
    localparam int AF    = 14;
    localparam int AE    = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sync_fifo_param_if #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) bus_a ();
    sync_fifo_param_if #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) bus_b ();

    sync_fifo_param #(
        .DATA_WIDTH (DW), .DEPTH (DEPTH), .AF_THRESH (AF), .AE_THRESH (AE), .FWFT (0)
    ) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (bus_a)
    );

    sync_fifo_param #(
        .DATA_WIDTH (DW), .DEPTH (DEPTH), .AF_THRESH (AF), .AE_THRESH (AE), .FWFT (1)
    ) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (bus_b)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        bus_a.flush = 1'b0; bus_a.wr_en = 1'b0; bus_a.rd_en = 1'b0; bus_a.data_in = '0;
        bus_b.flush = 1'b0; bus_b.wr_en = 1'b0; bus_b.rd_en = 1'b0; bus_b.data_in = '0;

        // ---------------- reset state ----------------
        #2 rst = 1'b0;
        #1;
        check("rst_count",    32'(bus_a.count), 0);
        check("rst_empty",    32'(bus_a.empty), 1);
        check("rst_full",     32'(bus_a.full), 0);
        check("rst_ae",       32'(bus_a.almost_empty), 1);
        check("rst_af",       32'(bus_a.almost_full), 0);
        check("rst_dout",     32'(bus_a.data_out), 0);
        check("rst_valid",    32'(bus_a.rd_valid), 0);
        check("rst_ovf",      32'(bus_a.overflow), 0);
        check("rst_udf",      32'(bus_a.underflow), 0);
        check("rst_b_valid",  32'(bus_b.rd_valid), 0);
        check("rst_b_empty",  32'(bus_b.empty), 1);
        @(posedge clk);
        #3 rst = 1'b1;
        cyc();

        // ---------------- fill 0x00..0x0F ----------------
        for (int i = 0; i < DEPTH; i++) begin
            bus_a.wr_en   = 1'b1;
            bus_a.data_in = 8'(i);
            cyc();
            check($sformatf("fill_count[%0d]", i), 32'(bus_a.count), 32'(i + 1));
            check($sformatf("fill_af[%0d]", i),    32'(bus_a.almost_full), 32'((i + 1) >= AF));
            check($sformatf("fill_ae[%0d]", i),    32'(bus_a.almost_empty), 32'((i + 1) <= AE));
            check($sformatf("fill_full[%0d]", i),  32'(bus_a.full), 32'((i + 1) == DEPTH));
            check($sformatf("fill_empty[%0d]", i), 32'(bus_a.empty), 0);
        end

        // ---------------- overflow: 17th write dropped ----------------
        bus_a.data_in = 8'hEE;
        cyc();
        bus_a.wr_en = 1'b0;
        check("ovf_count", 32'(bus_a.count), 16);
        check("ovf_flag",  32'(bus_a.overflow), 1);
        check("ovf_full",  32'(bus_a.full), 1);

        // ---------------- drain: 0x00..0x0F in order ----------------
        for (int i = 0; i < DEPTH; i++) begin
            bus_a.rd_en = 1'b1;
            cyc();
            check($sformatf("drain_valid[%0d]", i), 32'(bus_a.rd_valid), 1);
            check($sformatf("drain_data[%0d]", i),  32'(bus_a.data_out), 32'(i));
            check($sformatf("drain_count[%0d]", i), 32'(bus_a.count), 32'(DEPTH - 1 - i));
        end
        bus_a.rd_en = 1'b0;
        cyc();
        check("drain_idle_valid", 32'(bus_a.rd_valid), 0);
        check("drain_hold_data",  32'(bus_a.data_out), 32'h0F);
        check("drain_empty",      32'(bus_a.empty), 1);
        check("drain_ae",         32'(bus_a.almost_empty), 1);

        // ---------------- underflow ----------------
        bus_a.rd_en = 1'b1;
        cyc();
        bus_a.rd_en = 1'b0;
        check("udf_count", 32'(bus_a.count), 0);
        check("udf_flag",  32'(bus_a.underflow), 1);
        check("udf_valid", 32'(bus_a.rd_valid), 0);
        check("udf_ovf",   32'(bus_a.overflow), 1);

        // ---------------- flush clears flags and data_out ----------------
        bus_a.flush = 1'b1;
        cyc();
        bus_a.flush = 1'b0;
        check("flush_ovf",   32'(bus_a.overflow), 0);
        check("flush_udf",   32'(bus_a.underflow), 0);
        check("flush_dout",  32'(bus_a.data_out), 0);
        check("flush_empty", 32'(bus_a.empty), 1);

        // ---------------- simultaneous read/write across wrap ----------------
        for (int i = 0; i < 8; i++) begin
            bus_a.wr_en   = 1'b1;
            bus_a.data_in = 8'(8'h10 + i);
            cyc();
        end
        check("sim_pre_count", 32'(bus_a.count), 8);
        for (int k = 0; k < 40; k++) begin
            bus_a.wr_en   = 1'b1;
            bus_a.rd_en   = 1'b1;
            bus_a.data_in = 8'(8'h18 + k);
            cyc();
            check($sformatf("sim_count[%0d]", k), 32'(bus_a.count), 8);
            check($sformatf("sim_valid[%0d]", k), 32'(bus_a.rd_valid), 1);
            check($sformatf("sim_data[%0d]", k),  32'(bus_a.data_out), 32'(8'h10 + k));
        end
        bus_a.rd_en = 1'b0;

        // ---------------- full + read: read wins, write rejected ----------------
        for (int i = 0; i < 8; i++) begin
            bus_a.wr_en   = 1'b1;
            bus_a.data_in = 8'(8'h40 + i);
            cyc();
        end
        check("fr_pre_full", 32'(bus_a.full), 1);
        bus_a.wr_en   = 1'b1;
        bus_a.rd_en   = 1'b1;
        bus_a.data_in = 8'h99;
        cyc();
        bus_a.wr_en = 1'b0;
        bus_a.rd_en = 1'b0;
        check("fr_count", 32'(bus_a.count), 15);
        check("fr_full",  32'(bus_a.full), 0);
        check("fr_data",  32'(bus_a.data_out), 32'h38);
        check("fr_valid", 32'(bus_a.rd_valid), 1);
        check("fr_ovf",   32'(bus_a.overflow), 1);
        bus_a.rd_en = 1'b1;
        cyc();
        bus_a.rd_en = 1'b0;
        check("fr_next_data",  32'(bus_a.data_out), 32'h39);
        check("fr_next_count", 32'(bus_a.count), 14);

        // ---------------- FWFT ----------------
        bus_b.wr_en   = 1'b1;
        bus_b.data_in = 8'hA5;
        cyc();
        bus_b.wr_en = 1'b0;
        check("fwft_data",  32'(bus_b.data_out), 32'hA5);
        check("fwft_valid", 32'(bus_b.rd_valid), 1);
        check("fwft_count", 32'(bus_b.count), 1);
        cyc();
        check("fwft_hold_data", 32'(bus_b.data_out), 32'hA5);
        bus_b.rd_en = 1'b1;
        cyc();
        bus_b.rd_en = 1'b0;
        check("fwft_pop_valid", 32'(bus_b.rd_valid), 0);
        check("fwft_pop_empty", 32'(bus_b.empty), 1);
        bus_b.wr_en = 1'b1; bus_b.data_in = 8'hB1;
        cyc();
        bus_b.data_in = 8'hB2;
        cyc();
        bus_b.wr_en = 1'b0;
        check("fwft_b1", 32'(bus_b.data_out), 32'hB1);
        bus_b.rd_en = 1'b1;
        cyc();
        check("fwft_b2",       32'(bus_b.data_out), 32'hB2);
        check("fwft_b2_valid", 32'(bus_b.rd_valid), 1);
        cyc();
        bus_b.rd_en = 1'b0;
        check("fwft_end_valid", 32'(bus_b.rd_valid), 0);

        // ---------------- async reset mid-transfer at count=5 ----------------
        bus_a.flush = 1'b1;
        cyc();
        bus_a.flush = 1'b0;
        for (int i = 0; i < 6; i++) begin
            bus_a.wr_en   = 1'b1;
            bus_a.data_in = 8'(8'h50 + i);
            cyc();
        end
        bus_a.wr_en = 1'b0;
        bus_a.rd_en = 1'b1;
        cyc();
        bus_a.rd_en = 1'b0;
        check("ar_pre_count", 32'(bus_a.count), 5);
        check("ar_pre_data",  32'(bus_a.data_out), 32'h50);
        #3 rst = 1'b0;
        #1;
        check("ar_count",  32'(bus_a.count), 0);
        check("ar_empty",  32'(bus_a.empty), 1);
        check("ar_dout",   32'(bus_a.data_out), 0);
        check("ar_valid",  32'(bus_a.rd_valid), 0);
        check("ar_b_dout", 32'(bus_b.data_out), 0);
        #1 rst = 1'b1;
        cyc();
        bus_a.wr_en   = 1'b1;
        bus_a.data_in = 8'h77;
        cyc();
        bus_a.wr_en = 1'b0;
        bus_a.rd_en = 1'b1;
        cyc();
        bus_a.rd_en = 1'b0;
        check("ar_first_data",  32'(bus_a.data_out), 32'h77);
        check("ar_first_valid", 32'(bus_a.rd_valid), 1);
        check("ar_first_count", 32'(bus_a.count), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
